// File: rtl/pacman_pkg.sv
// Shared constants and types for the background tile path.
package pacman_pkg;

   localparam int TILE_BITS = 4;
   localparam int MAP_COLS  = 32;
   localparam int MAP_ROWS  = 32;
   localparam int WORD_BITS = 32;
   localparam int WR_BITS   = 5;

   localparam int WR_TOGGLE_BIT = 0;
   localparam int WR_START_BIT  = 1;
   localparam int WR_END_BIT    = 2;

   typedef enum logic [1:0] {
      ST_ARM    = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UNPACK = 2'd2
   } loader_state_e;

endpackage

// File: rtl/background_loader_if.sv
// PIO input pair, renderer read port and loader status, bundled for the loader.
interface background_loader_if;
   import pacman_pkg::*;

   logic [WORD_BITS-1:0]                 background_data;
   logic [WR_BITS-1:0]                   background_wr;
   logic                                 vsync;
   logic [$clog2(MAP_COLS*MAP_ROWS)-1:0] rd_addr;
   logic [TILE_BITS-1:0]                 rd_data;
   logic                                 busy;
   logic                                 frame_pending;
   logic                                 swapped;
   logic                                 front_page;
   logic                                 err_overrun;
   logic                                 err_overflow;

   modport master (
      output background_data, background_wr, vsync, rd_addr,
      input  rd_data, busy, frame_pending, swapped, front_page, err_overrun, err_overflow
   );

   modport slave (
      input  background_data, background_wr, vsync, rd_addr,
      output rd_data, busy, frame_pending, swapped, front_page, err_overrun, err_overflow
   );

endinterface

// File: rtl/tile_page_ram.sv
// Simple dual-port tile RAM: one write port, one registered read port.
module tile_page_ram #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; cleared by reset so rd_data starts at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_o <= {DATA_W{1'b0}};
      end else begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/background_loader.sv
// Unpacks toggle-handshaked PIO words of tile codes into the back page of a
// double-buffered tile map and swaps pages on vsync once a frame is complete.
module background_loader #(
   parameter int TILE_BITS      = 4,
   parameter int TILES_PER_WORD = 8,
   parameter int MAP_TILES      = 1024,
   parameter int WORDS_PER_MAP  = 128
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   background_loader_if.slave bus
);
   import pacman_pkg::*;

   localparam int WORD_W = TILE_BITS * TILES_PER_WORD;
   localparam int NIB_W  = $clog2(TILES_PER_WORD);
   localparam int PTR_W  = $clog2(WORDS_PER_MAP) + 1;
   localparam int ADDR_W = $clog2(MAP_TILES) + 1;
   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(WORDS_PER_MAP);
   localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(TILES_PER_WORD - 1);

   loader_state_e     state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [NIB_W-1:0]  nib_q, nib_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              end_q, end_d;
   logic              pend_q, pend_d;
   logic              fp_q, fp_d;
   logic              swap_q, swap_d;
   logic              ovr_q, ovr_d;
   logic              ofl_q, ofl_d;
   logic              busy_q;
   logic              tog_q;
   logic              vsync_q;

   logic              evt_s, rise_s, can_take_s, start_s, take_s, we_s;
   logic [PTR_W-1:0]  base_ptr_s;
   logic [ADDR_W-1:0] waddr_s, raddr_s;
   logic              unused_s;

   // In ARM the toggle history is still being loaded, so no event can fire.
   assign evt_s    = (state_q != ST_ARM) && (bus.background_wr[WR_TOGGLE_BIT] != tog_q);
   assign rise_s   = bus.vsync && !vsync_q;
   assign waddr_s  = {~fp_q, ptr_q[PTR_W-2:0], nib_q};
   assign raddr_s  = {fp_q, bus.rd_addr};
   assign unused_s = ^bus.background_wr[WR_BITS-1:WR_END_BIT+1];

   // Next-state: page swap, unpack sequencing and word acceptance.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      nib_d      = nib_q;
      ptr_d      = ptr_q;
      end_d      = end_q;
      pend_d     = pend_q;
      fp_d       = fp_q;
      swap_d     = 1'b0;
      we_s       = 1'b0;
      can_take_s = 1'b0;
      base_ptr_s = ptr_q;

      if (rise_s && pend_q) begin
         fp_d   = ~fp_q;
         pend_d = 1'b0;
         swap_d = 1'b1;
      end else begin
         swap_d = 1'b0;
      end

      case (state_q)
         ST_ARM:  state_d = ST_IDLE;
         ST_IDLE: can_take_s = 1'b1;
         ST_UNPACK: begin
            we_s    = 1'b1;
            shift_d = shift_q >> TILE_BITS;
            nib_d   = nib_q + NIB_W'(1);
            if (nib_q == NIB_LAST) begin
               can_take_s = 1'b1;
               base_ptr_s = ptr_q + PTR_W'(1);
               ptr_d      = base_ptr_s;
               pend_d     = pend_d | end_q;
               state_d    = ST_IDLE;
            end else begin
               can_take_s = 1'b0;
            end
         end
         default: state_d = ST_ARM;
      endcase

      // Frame start rewinds the pointer, so it bypasses the overflow check.
      start_s = evt_s && can_take_s && bus.background_wr[WR_START_BIT];
      take_s  = evt_s && can_take_s && (start_s || (base_ptr_s != PTR_FULL));
      ovr_d   = (ovr_q && !start_s) || (evt_s && !can_take_s);
      ofl_d   = (ofl_q && !start_s) || (evt_s && can_take_s && !take_s);

      if (take_s) begin
         state_d = ST_UNPACK;
         shift_d = bus.background_data[WORD_W-1:0];
         nib_d   = {NIB_W{1'b0}};
         end_d   = bus.background_wr[WR_END_BIT];
         ptr_d   = start_s ? {PTR_W{1'b0}} : base_ptr_s;
      end else begin
         end_d = end_q;
      end
   end

   // State and flag registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= ST_ARM;
         shift_q <= {WORD_W{1'b0}};
         nib_q   <= {NIB_W{1'b0}};
         ptr_q   <= {PTR_W{1'b0}};
         end_q   <= 1'b0;
         pend_q  <= 1'b0;
         fp_q    <= 1'b0;
         swap_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ofl_q   <= 1'b0;
         busy_q  <= 1'b0;
         tog_q   <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         nib_q   <= nib_d;
         ptr_q   <= ptr_d;
         end_q   <= end_d;
         pend_q  <= pend_d;
         fp_q    <= fp_d;
         swap_q  <= swap_d;
         ovr_q   <= ovr_d;
         ofl_q   <= ofl_d;
         busy_q  <= (state_d == ST_UNPACK);
         tog_q   <= bus.background_wr[WR_TOGGLE_BIT];
         vsync_q <= bus.vsync;
      end
   end

   tile_page_ram #(
      .DATA_W (TILE_BITS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .we_i    (we_s),
      .waddr_i (waddr_s),
      .wdata_i (shift_q[TILE_BITS-1:0]),
      .raddr_i (raddr_s),
      .rdata_o (bus.rd_data)
   );

   assign bus.busy          = busy_q;
   assign bus.frame_pending = pend_q;
   assign bus.swapped       = swap_q;
   assign bus.front_page    = fp_q;
   assign bus.err_overrun   = ovr_q;
   assign bus.err_overflow  = ofl_q;

endmodule
